nfu_1a_lookahead_sched: RTL

- Zero-skipping scheduler that sits directly upstream of the D=1/W=0 NFU-1A mux stage.
- Buffers a current and a lookahead input brick of Tn neurons.
- Per lane: issues the current value if it is non-zero; otherwise borrows the same lane's non-zero value from the next brick.
- Drives the cur/repl data buses and the per-(lane,filter) select lines of NFU-1A through a registered valid/ready output stage.

---
 rtl/nfu_pkg.sv | 36 +++
 rtl/nfu_lane_pick.sv | 15 +
 rtl/nfu_1a_lookahead_sched.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/nfu_pkg.sv
// Shared types and helpers for the NFU-1A lookahead zero-skipping scheduler.
package nfu_pkg;

  localparam int BIT_WIDTH = 16;
  localparam int Tn        = 16;
  localparam int TnxTn     = Tn * Tn;
  localparam int TAG_W     = 8;
  localparam int CNT_W     = $clog2(Tn + 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } schedState_t;

  typedef struct packed {
    logic [BIT_WIDTH*Tn-1:0] data;
    logic [Tn-1:0]           pending;
    logic                    last;
    logic [TAG_W-1:0]        tag;
  } brickSlot_t;

  function automatic logic [CNT_W-1:0] popCount(input logic [Tn-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int k = 0; k < Tn; k++) c = c + CNT_W'(v[k]);
    return c;
  endfunction

  function automatic logic [31:0] satAdd(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

endpackage

// File: rtl/nfu_lane_pick.sv
// Per-lane operand selector: own value if pending, else borrow the lookahead lane.
module nfu_lane_pick (
  input  logic cur_pend,
  input  logic nxt_pend,
  input  logic nxt_ok,
  output logic sel,
  output logic lane_valid,
  output logic clr_nxt
);

  assign sel        = !cur_pend && nxt_ok && nxt_pend;
  assign lane_valid = cur_pend || sel;
  assign clr_nxt    = sel;

endmodule

// File: rtl/nfu_1a_lookahead_sched.sv
// Two-slot lookahead zero-skipping scheduler feeding the NFU-1A mux stage.
// Optional statistics counters are enabled by defining NFU1A_SCHED_STATS_EN.
module nfu_1a_lookahead_sched
  import nfu_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [BIT_WIDTH*Tn-1:0] i_in_data,
  input  logic                    i_in_last,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  output logic [BIT_WIDTH*Tn-1:0] o_cur_inputs,
  output logic [BIT_WIDTH*Tn-1:0] o_repl_cands,
  output logic [TnxTn-1:0]        o_sel_lines,
  output logic [Tn-1:0]           o_lane_valid,
  output logic [TAG_W-1:0]        o_tag,
  output logic                    o_last,
  output logic                    o_valid,
  input  logic                    i_out_ready
`ifdef NFU1A_SCHED_STATS_EN
  ,
  output logic [31:0]             o_stat_zero_skipped,
  output logic [31:0]             o_stat_borrowed,
  output logic [31:0]             o_stat_issues
`endif
);

  schedState_t state, stateNext;
  brickSlot_t  cur, nxt, inBrick, nxtShift;
  logic [TAG_W-1:0] tagCnt;
  logic [Tn-1:0]    laneSel, laneValid, clrNxt, outSel;
  logic curHeld, nxtHeld, outFree, nxtOk;
  logic skip, issue, consume, accept;

  assign curHeld = (state != EMPTY);
  assign nxtHeld = (state == TWO);
  assign outFree = !o_valid || i_out_ready;
  assign nxtOk   = nxtHeld && !cur.last;

  // A brick with nothing left to issue is dropped at once, unless it must carry o_last.
  assign skip    = curHeld && (cur.pending == '0) && !cur.last;
  assign issue   = curHeld && (nxtHeld || cur.last) && outFree && !skip;
  assign consume = issue || skip;

  assign o_in_ready = !i_rst && (!nxtHeld || consume);
  assign accept     = i_in_valid && o_in_ready;

  for (genvar k = 0; k < Tn; k++) begin : g_lane
    nfu_lane_pick u_pick (
      .cur_pend   (cur.pending[k]),
      .nxt_pend   (nxt.pending[k]),
      .nxt_ok     (nxtOk),
      .sel        (laneSel[k]),
      .lane_valid (laneValid[k]),
      .clr_nxt    (clrNxt[k])
    );
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    inBrick      = '0;
    inBrick.data = i_in_data;
    inBrick.last = i_in_last;
    inBrick.tag  = tagCnt;
    for (int k = 0; k < Tn; k++)
      inBrick.pending[k] = |i_in_data[k*BIT_WIDTH +: BIT_WIDTH];

    nxtShift = nxt;
    if (issue) nxtShift.pending = nxt.pending & ~clrNxt;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      EMPTY: if (accept) stateNext = ONE;
      ONE: begin
        if (consume)     stateNext = accept ? ONE : EMPTY;
        else if (accept) stateNext = TWO;
      end
      TWO:     if (consume) stateNext = accept ? TWO : ONE;
      default: stateNext = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= EMPTY;
      cur    <= '0;
      nxt    <= '0;
      tagCnt <= '0;
    end else begin
      state <= stateNext;
      if (accept) tagCnt <= tagCnt + TAG_W'(1);
      if (consume) begin
        if (nxtHeld) begin
          cur <= nxtShift;
          if (accept) nxt <= inBrick;
        end else if (accept) begin
          cur <= inBrick;
        end
      end else if (accept) begin
        if (!curHeld) cur <= inBrick;
        else          nxt <= inBrick;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid      <= 1'b0;
      o_cur_inputs <= '0;
      o_repl_cands <= '0;
      outSel       <= '0;
      o_lane_valid <= '0;
      o_tag        <= '0;
      o_last       <= 1'b0;
    end else if (issue) begin
      o_valid      <= 1'b1;
      o_cur_inputs <= cur.data;
      o_repl_cands <= nxtHeld ? nxt.data : '0;
      outSel       <= laneSel;
      o_lane_valid <= laneValid;
      o_tag        <= cur.tag;
      o_last       <= cur.last;
    end else if (i_out_ready) begin
      o_valid <= 1'b0;
    end
  end

  // Each lane's select is fanned out across all Tn filters.
  for (genvar i = 0; i < Tn; i++) begin : g_sel
    assign o_sel_lines[i*Tn +: Tn] = {Tn{outSel[i]}};
  end

`ifdef NFU1A_SCHED_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_stat_zero_skipped <= '0;
      o_stat_borrowed     <= '0;
      o_stat_issues       <= '0;
    end else if (issue) begin
      o_stat_zero_skipped <= satAdd(o_stat_zero_skipped, 32'(popCount(~cur.pending)));
      o_stat_borrowed     <= satAdd(o_stat_borrowed, 32'(popCount(laneSel)));
      o_stat_issues       <= satAdd(o_stat_issues, 32'd1);
    end
  end
`endif

endmodule
